wb_trace_fifo: RTL and testbench
================================

WB_TRACE_FIFO -- requirements
Module: wb_trace_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count (power of two, >= 2).
REQ-002 SHALL have parameter CNTW, default 8, width of drop counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 resets on the clk edge).
REQ-005 SHALL have port flush  input  1  synchronous clear of buffered events.
REQ-006 SHALL have port ev_valid  input  1  CPU write-back event present this cycle.
REQ-007 SHALL have port ev_kind  input  1  0 = GRF write, 1 = DM write.
REQ-008 SHALL have port ev_pc  input  32  PC of the retiring instruction.
REQ-009 SHALL have port ev_addr  input  32  GRF: register number in [4:0]; DM: byte address.
REQ-010 SHALL have port ev_data  input  32  written value.
REQ-011 SHALL have port out_valid  output  1  head entry available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head.
REQ-013 SHALL have ports out_kind/out_pc/out_addr/out_data  output  1/32/32/32  head entry fields.
REQ-014 SHALL have port level  output  clog2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port overflow  output  1  sticky: an event was lost to a full FIFO.
REQ-016 SHALL have port drop_cnt  output  CNTW  count of lost events, saturating.

Function
REQ-017 SHALL treat an event as a push candidate when ev_valid==1 and not (ev_kind==0 and ev_addr[4:0]==0); $0 writes are discarded silently (no drop, no overflow).
REQ-018 SHALL store candidates in order in a DEPTH-entry circular buffer; read/write pointers wrap modulo DEPTH.
REQ-019 SHALL drive out_valid = (level != 0) and out_* from the head entry, registered storage only; no input-to-output combinational bypass.
REQ-020 SHALL have latency one cycle: candidate pushed at edge N into an empty FIFO gives out_valid==1 in the cycle after edge N.
REQ-021 SHALL pop the head on an edge where out_valid==1 and out_ready==1; out_ready with out_valid==0 has no effect.
REQ-022 SHALL hold out_* stable while out_valid==1 and out_ready==0.
REQ-023 SHALL accept a push when level < DEPTH, or when level == DEPTH and a pop occurs the same edge (level stays DEPTH, no drop).
REQ-024 SHALL, on a push candidate with level == DEPTH and no same-edge pop, discard the event, set overflow, increment drop_cnt (saturate at all-ones).
REQ-025 SHALL on simultaneous push and pop with level in 1..DEPTH-1 keep level unchanged; on empty FIFO push with out_ready==1, perform push only.
REQ-026 SHALL, when flush==1, empty the FIFO (level 0, pointers 0) on that edge, ignore same-edge push and pop, and not count the ignored event as a drop; overflow and drop_cnt retained.

Reset
REQ-027 SHALL, on an edge with reset==0, set level=0, pointers=0, out_valid=0, overflow=0, drop_cnt=0; reset has priority over flush, push and pop.
REQ-028 SHALL leave storage contents undefined after reset; out_kind/out_pc/out_addr/out_data SHALL read 0 while out_valid==0.
REQ-029 SHALL discard a mid-stream FIFO contents on reset; first post-reset push appears one cycle later per REQ-020.

Configuration
REQ-030 SHALL, with macro WB_TRACE_SEQ_EN defined, add output port out_seq (16 bits): sequence number of the head entry, assigned from a 16-bit counter incremented per accepted push (wraps 0xFFFF->0), reset to 0; dropped, filtered and flushed events do not consume a number.
REQ-031 SHALL, without WB_TRACE_SEQ_EN, omit out_seq and its counter; all other behaviour identical.

Verification
REQ-032 SHALL cover: reset==0 two edges then release; push GRF r8=0x1234 at pc 0x3000 -> next cycle out_valid=1, out_addr=8, out_data=0x1234, level=1.
REQ-033 SHALL cover: push GRF $0 write data 0xFFFF with ev_valid=1 -> level stays 0, overflow=0, drop_cnt=0.
REQ-034 SHALL cover: out_ready=0, push 10 DM events with DEPTH=8 -> level=8, overflow=1, drop_cnt=2; then drain -> first 8 events in order, pc 0x3000..0x301C.
REQ-035 SHALL cover: full FIFO, push and out_ready=1 same edge -> level stays 8, drop_cnt unchanged, new event emerges last.
REQ-036 SHALL cover: 5 entries buffered, flush=1 with concurrent push -> level=0, out_valid=0 next cycle, drop_cnt unchanged; with WB_TRACE_SEQ_EN, next accepted event carries out_seq=5.

Source files
------------

// File: rtl/wb_trace_fifo_if.sv
// Bus bundle for wb_trace_fifo: write-back event input, head-entry output and status.
// Optional WB_TRACE_SEQ_EN adds the 16-bit out_seq field.
interface wb_trace_fifo_if #(
  parameter int DEPTH = 8,
  parameter int CNTW  = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            ev_valid;
  logic            ev_kind;
  logic [31:0]     ev_pc;
  logic [31:0]     ev_addr;
  logic [31:0]     ev_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_kind;
  logic [31:0]     out_pc;
  logic [31:0]     out_addr;
  logic [31:0]     out_data;
  logic [LW-1:0]   level;
  logic            overflow;
  logic [CNTW-1:0] drop_cnt;
`ifdef WB_TRACE_SEQ_EN
  logic [15:0]     out_seq;

  modport master (
    output flush, ev_valid, ev_kind, ev_pc, ev_addr, ev_data, out_ready,
    input  out_valid, out_kind, out_pc, out_addr, out_data, level, overflow, drop_cnt, out_seq
  );
  modport slave (
    input  flush, ev_valid, ev_kind, ev_pc, ev_addr, ev_data, out_ready,
    output out_valid, out_kind, out_pc, out_addr, out_data, level, overflow, drop_cnt, out_seq
  );
`else
  modport master (
    output flush, ev_valid, ev_kind, ev_pc, ev_addr, ev_data, out_ready,
    input  out_valid, out_kind, out_pc, out_addr, out_data, level, overflow, drop_cnt
  );
  modport slave (
    input  flush, ev_valid, ev_kind, ev_pc, ev_addr, ev_data, out_ready,
    output out_valid, out_kind, out_pc, out_addr, out_data, level, overflow, drop_cnt
  );
`endif
endinterface

// File: rtl/wb_trace_fifo.sv
// CPU write-back trace FIFO: filters $0 writes, buffers events, counts overflow drops.
// Define WB_TRACE_SEQ_EN to tag every accepted event with a 16-bit sequence number (out_seq).
module wb_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int CNTW  = 8
) (
  input  logic           clk,
  input  logic           reset,
  wb_trace_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
`ifdef WB_TRACE_SEQ_EN
    logic [15:0] seq;
`endif
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          wr_entry;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic            overflow;
  logic [CNTW-1:0] drop_cnt;
`ifdef WB_TRACE_SEQ_EN
  logic [15:0]     seq_cnt;
`endif

  logic cand, full, pop, push, drop;

  // A GRF write to register 0 is architecturally a no-op, so it never enters the trace.
  assign cand = bus.ev_valid && !(!bus.ev_kind && bus.ev_addr[4:0] == 5'd0);
  assign full = (level == LW'(DEPTH));
  assign pop  = !bus.flush && (level != '0) && bus.out_ready;
  assign push = !bus.flush && cand && (!full || pop);
  assign drop = !bus.flush && cand && full && !pop;

  always_comb begin
    wr_entry      = '0;
    wr_entry.kind = bus.ev_kind;
    wr_entry.pc   = bus.ev_pc;
    wr_entry.addr = bus.ev_addr;
    wr_entry.data = bus.ev_data;
`ifdef WB_TRACE_SEQ_EN
    wr_entry.seq  = seq_cnt;
`endif
  end

  // NOTE: storage has no reset; out_valid gates every read, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (reset && push) mem[wr_ptr] <= wr_entry;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
`ifdef WB_TRACE_SEQ_EN
      seq_cnt  <= '0;
`endif
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      end
`ifdef WB_TRACE_SEQ_EN
      if (push) seq_cnt <= seq_cnt + 16'd1;
`endif
    end
  end

  // Head fields read as zero while empty so stale storage never leaks out.
  assign head          = mem[rd_ptr];
  assign bus.out_valid = (level != '0);
  assign bus.out_kind  = bus.out_valid ? head.kind : 1'b0;
  assign bus.out_pc    = bus.out_valid ? head.pc   : 32'd0;
  assign bus.out_addr  = bus.out_valid ? head.addr : 32'd0;
  assign bus.out_data  = bus.out_valid ? head.data : 32'd0;
`ifdef WB_TRACE_SEQ_EN
  assign bus.out_seq   = bus.out_valid ? head.seq  : 16'd0;
`endif
  assign bus.level     = level;
  assign bus.overflow  = overflow;
  assign bus.drop_cnt  = drop_cnt;
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Scoreboard bench for wb_trace_fifo: directed stimulus pushes expected entries,
// a negedge monitor pops and compares each handshake.
module tb_wb_trace_fifo;
  logic clk = 1'b0;
  logic reset;
  bit   started = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_seq = 0;

  typedef struct {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] seq;
  } exp_t;
  exp_t exp_q[$];

  wb_trace_fifo_if #(.DEPTH(8), .CNTW(8)) bus ();

  wb_trace_fifo #(.DEPTH(8), .CNTW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one event for a single edge; accept says whether it should enter the FIFO.
  task automatic ev_cycle(input logic kind, input logic [31:0] pc, input logic [31:0] addr,
                          input logic [31:0] data, input bit accept);
    exp_t e;
    bus.ev_valid = 1'b1;
    bus.ev_kind  = kind;
    bus.ev_pc    = pc;
    bus.ev_addr  = addr;
    bus.ev_data  = data;
    if (accept) begin
      e.kind = kind; e.pc = pc; e.addr = addr; e.data = data; e.seq = 16'(exp_seq);
      exp_q.push_back(e);
      exp_seq++;
    end
    cycle();
    bus.ev_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40 && bus.level != 0; i++) cycle();
    check(name, 32'(bus.level), 32'd0);
    bus.out_ready = 1'b0;
  endtask

  // Monitor: a handshake seen at negedge completes on the next rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (started && reset && !bus.flush) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_pc", bus.out_pc, 32'hDEAD_BEEF);
          end else begin
            e = exp_q.pop_front();
            check("out_kind", 32'(bus.out_kind), 32'(e.kind));
            check("out_pc",   bus.out_pc,   e.pc);
            check("out_addr", bus.out_addr, e.addr);
            check("out_data", bus.out_data, e.data);
`ifdef WB_TRACE_SEQ_EN
            check("out_seq",  32'(bus.out_seq), 32'(e.seq));
`endif
          end
        end else if (bus.out_valid === 1'b0) begin
          check("idle_fields_zero",
                32'(|{bus.out_kind, bus.out_pc, bus.out_addr, bus.out_data}), 32'd0);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.flush = 1'b0; bus.ev_valid = 1'b0; bus.ev_kind = 1'b0;
    bus.ev_pc = '0; bus.ev_addr = '0; bus.ev_data = '0; bus.out_ready = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    started = 1'b1;
    check("rst_level",     32'(bus.level),     32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_overflow",  32'(bus.overflow),  32'd0);
    check("rst_drop_cnt",  32'(bus.drop_cnt),  32'd0);

    // Single GRF write, one-cycle latency.
    ev_cycle(1'b0, 32'h3000, 32'd8, 32'h1234, 1'b1);
    check("grf_out_valid", 32'(bus.out_valid), 32'd1);
    check("grf_out_addr",  bus.out_addr,       32'd8);
    check("grf_out_data",  bus.out_data,       32'h1234);
    check("grf_level",     32'(bus.level),     32'd1);
    drain("grf_drain");

    // $0 write is filtered silently.
    ev_cycle(1'b0, 32'h3004, 32'd0, 32'hFFFF, 1'b0);
    check("r0_level",    32'(bus.level),    32'd0);
    check("r0_overflow", 32'(bus.overflow), 32'd0);
    check("r0_drop_cnt", 32'(bus.drop_cnt), 32'd0);

    // Ten DM writes into an 8-deep FIFO with no consumer.
    for (int i = 0; i < 10; i++)
      ev_cycle(1'b1, 32'h3000 + 32'(4 * i), 32'h100 + 32'(4 * i), 32'(i), i < 8);
    check("ovf_level",    32'(bus.level),    32'd8);
    check("ovf_overflow", 32'(bus.overflow), 32'd1);
    check("ovf_drop_cnt", 32'(bus.drop_cnt), 32'd2);
    drain("ovf_drain");

    // Full FIFO: push with same-edge pop is accepted without a drop.
    for (int i = 0; i < 8; i++)
      ev_cycle(1'b1, 32'h4000 + 32'(4 * i), 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 1'b1);
    bus.out_ready = 1'b1;
    ev_cycle(1'b1, 32'h5000, 32'h300, 32'h5555, 1'b1);
    bus.out_ready = 1'b0;
    check("fullpp_level",    32'(bus.level),    32'd8);
    check("fullpp_drop_cnt", 32'(bus.drop_cnt), 32'd2);
    drain("fullpp_drain");

    // Reset mid-stream discards buffered events and clears status.
    for (int i = 0; i < 3; i++)
      ev_cycle(1'b1, 32'h6000 + 32'(4 * i), 32'h400, 32'(i), 1'b1);
    reset = 1'b0;
    exp_q.delete();
    exp_seq = 0;
    cycle();
    reset = 1'b1;
    check("mrst_level",     32'(bus.level),     32'd0);
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_overflow",  32'(bus.overflow),  32'd0);
    check("mrst_drop_cnt",  32'(bus.drop_cnt),  32'd0);

    // Five buffered entries, then flush with a concurrent push.
    ev_cycle(1'b1, 32'h7000, 32'h500, 32'h70, 1'b1);
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_pc",    bus.out_pc,         32'h7000);
    for (int i = 1; i < 5; i++)
      ev_cycle(1'b1, 32'h7000 + 32'(4 * i), 32'h500, 32'h70 + 32'(i), 1'b1);
    check("pre_flush_level", 32'(bus.level), 32'd5);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.delete();
    ev_cycle(1'b1, 32'h7F00, 32'h600, 32'h77, 1'b0);
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    check("flush_level",     32'(bus.level),     32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_drop_cnt",  32'(bus.drop_cnt),  32'd0);
    exp_seq = 5;
    ev_cycle(1'b1, 32'h8000, 32'h700, 32'h88, 1'b1);
    check("after_flush_pc", bus.out_pc, 32'h8000);
`ifdef WB_TRACE_SEQ_EN
    check("after_flush_seq", 32'(bus.out_seq), 32'd5);
`endif
    drain("final_drain");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
